// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its read-side executor:
// opcodes, operands, the packed instruction word and the result type.
package instr_register_pkg;

  localparam int DEFAULT_RES_W = 64;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef logic signed [DEFAULT_RES_W-1:0] result_t;

endpackage

// File: rtl/instr_exec_alu.sv
// Combinational executor for one instruction. Operands are sign-extended to
// the full result width first, so MULT keeps the whole product and DIV/MOD
// cannot overflow on -2^31 / -1.
module instr_exec_alu
  import instr_register_pkg::*;
(
  input  opcode_t  opc,
  input  operand_t op_a,
  input  operand_t op_b,
  output result_t  result,
  output logic     div_err
);

  result_t a_ext;
  result_t b_ext;

  assign a_ext = result_t'(op_a);
  assign b_ext = result_t'(op_b);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    result  = '0;
    div_err = 1'b0;
    case (opc)
      ZERO:  result = '0;
      PASSA: result = a_ext;
      PASSB: result = b_ext;
      ADD:   result = a_ext + b_ext;
      SUB:   result = a_ext - b_ext;
      MULT:  result = a_ext * b_ext;
      DIV: begin
        if (op_b == '0) div_err = 1'b1;
        else            result  = a_ext / b_ext;
      end
      MOD: begin
        if (op_b == '0) div_err = 1'b1;
        else            result  = a_ext % b_ext;
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/instr_exec_reader.sv
// Walks the instruction register from entry 0, executes each word and offers
// the result on a valid/ready port. Define INSTR_EXEC_STATS_EN for counters.
module instr_exec_reader
  import instr_register_pkg::*;
#(
  parameter  int NUM_ENTRIES = 32,
  parameter  int RES_W       = DEFAULT_RES_W,
  localparam int PW          = $clog2(NUM_ENTRIES),
  localparam int CW          = PW + 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [CW-1:0]           num_instr,
  output logic [PW-1:0]           read_pointer,
  input  instruction_t            instruction_word,
  output logic signed [RES_W-1:0] result,
  output opcode_t                 result_opc,
  output logic [PW-1:0]           result_idx,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic                    div_err,
  output logic                    busy,
  output logic                    done
`ifdef INSTR_EXEC_STATS_EN
  ,
  output logic [15:0]             exec_count,
  output logic [15:0]             err_count
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_OUT, S_FIN} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             count_q, count_d;
  logic [CW-1:0]             ndone_q, ndone_d;
  logic [PW-1:0]             rptr_q, rptr_d;
  instruction_t              instr_q, instr_d;
  logic signed [RES_W-1:0]   result_q, result_d;
  opcode_t                   opc_q, opc_d;
  logic [PW-1:0]             idx_q, idx_d;
  logic                      valid_q, valid_d;
  logic                      div_err_q, div_err_d;
  logic                      done_q, done_d;

  result_t alu_result;
  logic    alu_div_err;
  logic    start_acc;
  logic    handshake;
  logic    last_entry;

  instr_exec_alu u_alu (
    .opc     (instr_q.opc),
    .op_a    (instr_q.op_a),
    .op_b    (instr_q.op_b),
    .result  (alu_result),
    .div_err (alu_div_err)
  );

  assign start_acc  = (state_q == S_IDLE) && start;
  assign handshake  = (state_q == S_OUT) && valid_q && result_ready;
  assign last_entry = (ndone_q + CW'(1)) == count_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    ndone_d   = ndone_q;
    rptr_d    = rptr_q;
    instr_d   = instr_q;
    result_d  = result_q;
    opc_d     = opc_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    div_err_d = div_err_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          if (num_instr == '0) begin
            done_d = 1'b1;
          end else begin
            count_d = (num_instr > CW'(NUM_ENTRIES)) ? CW'(NUM_ENTRIES) : num_instr;
            ndone_d = '0;
            rptr_d  = '0;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        instr_d = instruction_word;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        result_d  = RES_W'(alu_result);
        opc_d     = instr_q.opc;
        idx_d     = rptr_q;
        div_err_d = alu_div_err;
        valid_d   = 1'b1;
        state_d   = S_OUT;
      end
      S_OUT: begin
        if (handshake) begin
          valid_d = 1'b0;
          ndone_d = ndone_q + CW'(1);
          if (last_entry) begin
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            rptr_d  = (rptr_q == PW'(NUM_ENTRIES - 1)) ? '0 : rptr_q + PW'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the captured
  // instruction is reset too so the ALU never sees X after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      ndone_q   <= '0;
      rptr_q    <= '0;
      instr_q   <= '0;
      result_q  <= '0;
      opc_q     <= ZERO;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      div_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      ndone_q   <= ndone_d;
      rptr_q    <= rptr_d;
      instr_q   <= instr_d;
      result_q  <= result_d;
      opc_q     <= opc_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      div_err_q <= div_err_d;
      done_q    <= done_d;
    end
  end

  assign read_pointer = rptr_q;
  assign result       = result_q;
  assign result_opc   = opc_q;
  assign result_idx   = idx_q;
  assign result_valid = valid_q;
  assign div_err      = div_err_q;
  assign done         = done_q;
  assign busy         = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_OUT);

`ifdef INSTR_EXEC_STATS_EN
  logic [15:0] exec_cnt_q, exec_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    exec_cnt_d = exec_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (start_acc) begin
      exec_cnt_d = '0;
      err_cnt_d  = '0;
    end else if (handshake) begin
      if (exec_cnt_q != 16'hFFFF)             exec_cnt_d = exec_cnt_q + 16'd1;
      if (div_err_q && err_cnt_q != 16'hFFFF) err_cnt_d  = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exec_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      exec_cnt_q <= exec_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign exec_count = exec_cnt_q;
  assign err_count  = err_cnt_q;
`endif

endmodule

// File: tb/tb_instr_exec_reader.sv
// Directed bench for instr_exec_reader: table of instructions with expected
// results, plus stall, mid-run reset, empty-run and clamp sequences.
module tb_instr_exec_reader;
  import instr_register_pkg::*;

  localparam int N  = 32;
  localparam int PW = $clog2(N);
  localparam int CW = PW + 1;
  localparam int NV = 14;

  typedef struct {
    instruction_t ins;
    logic [63:0]  exp_res;
    logic         exp_err;
  } vec_t;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                start = 1'b0;
  logic [CW-1:0]       num_instr = '0;
  logic [PW-1:0]       read_pointer;
  instruction_t        instruction_word;
  logic signed [63:0]  result;
  opcode_t             result_opc;
  logic [PW-1:0]       result_idx;
  logic                result_valid;
  logic                result_ready = 1'b1;
  logic                div_err;
  logic                busy;
  logic                done;
`ifdef INSTR_EXEC_STATS_EN
  logic [15:0]         exec_count;
  logic [15:0]         err_count;
`endif

  instruction_t mem [N];
  logic [63:0]  exp_res [N];
  logic         exp_err [N];
  vec_t         vec [NV];
  int           checks = 0;
  int           errors = 0;

  assign instruction_word = mem[read_pointer];

  always #5 clk = ~clk;

  instr_exec_reader #(.NUM_ENTRIES(N), .RES_W(64)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .num_instr        (num_instr),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .result           (result),
    .result_opc       (result_opc),
    .result_idx       (result_idx),
    .result_valid     (result_valid),
    .result_ready     (result_ready),
    .div_err          (div_err),
    .busy             (busy),
`ifdef INSTR_EXEC_STATS_EN
    .exec_count       (exec_count),
    .err_count        (err_count),
`endif
    .done             (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for result_valid; returns edges counted since the last start/handshake.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!result_valid && cyc < 40) begin
      step();
      cyc++;
    end
    check("valid_timeout", 64'(result_valid), 64'd1);
  endtask

  task automatic check_result(input int k);
    check($sformatf("result[%0d]", k), result, exp_res[k]);
    check($sformatf("opc[%0d]", k), 64'(result_opc), 64'(mem[k].opc));
    check($sformatf("idx[%0d]", k), 64'(result_idx), 64'(k));
    check($sformatf("div_err[%0d]", k), 64'(div_err), 64'(exp_err[k]));
  endtask

  task automatic run_check(input int n_req, input int n_exp);
    int cyc;
    num_instr = CW'(n_req);
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    for (int k = 0; k < n_exp; k++) begin
      wait_valid(cyc);
      check($sformatf("latency[%0d]", k), 64'(cyc), 64'd3);
      check($sformatf("done_early[%0d]", k), 64'(done), 64'd0);
      check_result(k);
      step();
    end
    check("done_pulse", 64'(done), 64'd1);
    check("busy_at_fin", 64'(busy), 64'd0);
    check("rptr_final", 64'(read_pointer), 64'(n_exp - 1));
    step();
    check("done_single", 64'(done), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_result"}, result, 64'd0);
    check({tag, "_opc"}, 64'(result_opc), 64'(ZERO));
    check({tag, "_idx"}, 64'(result_idx), 64'd0);
    check({tag, "_rptr"}, 64'(read_pointer), 64'd0);
    check({tag, "_ctrl"}, {60'd0, result_valid, div_err, busy, done}, 64'd0);
  endtask

  initial begin
    vec[0]  = '{ins: '{opc: ADD,   op_a: 5,  op_b: 3},  exp_res: 64'd8,   exp_err: 1'b0};
    vec[1]  = '{ins: '{opc: SUB,   op_a: 5,  op_b: 8},  exp_res: -64'sd3, exp_err: 1'b0};
    vec[2]  = '{ins: '{opc: MULT,  op_a: -4, op_b: 7},  exp_res: -64'sd28, exp_err: 1'b0};
    vec[3]  = '{ins: '{opc: MULT,  op_a: 32'h7FFFFFFF, op_b: 32'h7FFFFFFF},
                exp_res: 64'h3FFFFFFF00000001, exp_err: 1'b0};
    vec[4]  = '{ins: '{opc: DIV,   op_a: -7, op_b: 2},  exp_res: -64'sd3, exp_err: 1'b0};
    vec[5]  = '{ins: '{opc: MOD,   op_a: -7, op_b: 2},  exp_res: -64'sd1, exp_err: 1'b0};
    vec[6]  = '{ins: '{opc: DIV,   op_a: 9,  op_b: 0},  exp_res: 64'd0,   exp_err: 1'b1};
    vec[7]  = '{ins: '{opc: MOD,   op_a: 9,  op_b: 0},  exp_res: 64'd0,   exp_err: 1'b1};
    vec[8]  = '{ins: '{opc: PASSA, op_a: -9, op_b: 4},  exp_res: -64'sd9, exp_err: 1'b0};
    vec[9]  = '{ins: '{opc: PASSB, op_a: -9, op_b: 4},  exp_res: 64'd4,   exp_err: 1'b0};
    vec[10] = '{ins: '{opc: ZERO,  op_a: 1,  op_b: 2},  exp_res: 64'd0,   exp_err: 1'b0};
    vec[11] = '{ins: '{opc: opcode_t'(4'hB), op_a: 3, op_b: 4}, exp_res: 64'd0, exp_err: 1'b0};
    vec[12] = '{ins: '{opc: DIV,   op_a: 32'sh80000000, op_b: -1},
                exp_res: 64'h0000000080000000, exp_err: 1'b0};
    vec[13] = '{ins: '{opc: MOD,   op_a: 7,  op_b: -2}, exp_res: 64'd1,   exp_err: 1'b0};

    for (int i = 0; i < N; i++) begin
      if (i < NV) begin
        mem[i]     = vec[i].ins;
        exp_res[i] = vec[i].exp_res;
        exp_err[i] = vec[i].exp_err;
      end else begin
        mem[i]     = '{opc: ADD, op_a: i, op_b: 1};
        exp_res[i] = 64'(i + 1);
        exp_err[i] = 1'b0;
      end
    end

    #12;
    check_reset_state("reset");
    reset_n = 1'b1;
    step();

    // Three-entry run: ADD, SUB, MULT.
    run_check(3, 3);

    // Clamp: 40 requested, all 32 entries executed (covers the whole table).
    run_check(40, N);

    // Empty run: done pulses once, busy stays low.
    num_instr = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("empty_done", 64'(done), 64'd1);
    check("empty_busy", 64'(busy), 64'd0);
    step();
    check("empty_done_single", 64'(done), 64'd0);
    check("empty_busy2", 64'(busy), 64'd0);

    // Stall 5 cycles in OUT; a start during the stall must be ignored.
    begin
      int cyc;
      result_ready = 1'b0;
      num_instr = CW'(2);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_valid(cyc);
      for (int i = 0; i < 5; i++) begin
        if (i == 2) begin
          num_instr = CW'(3);
          start = 1'b1;
        end
        step();
        start = 1'b0;
        check($sformatf("stall_valid[%0d]", i), 64'(result_valid), 64'd1);
        check($sformatf("stall_hold[%0d]", i),
              {result[31:0], 8'(result_opc), 8'(result_idx), 8'(read_pointer), 8'd0},
              {32'd8, 8'(ADD), 8'd0, 8'd0, 8'd0});
      end
      result_ready = 1'b1;
      step();
      wait_valid(cyc);
      check_result(1);
      step();
      check("stall_done", 64'(done), 64'd1);
      step();
      check("stall_no_restart", 64'(busy), 64'd0);
    end

    // Reset while a result is held in OUT.
    begin
      int cyc;
      result_ready = 1'b0;
      num_instr = CW'(3);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_valid(cyc);
      step();
      step();
      reset_n = 1'b0;
      #2;
      check_reset_state("midrun_reset");
      step();
      reset_n = 1'b1;
      result_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        step();
        check($sformatf("no_done_after_reset[%0d]", i), {62'd0, done, busy}, 64'd0);
      end
      run_check(3, 3);
    end

`ifdef INSTR_EXEC_STATS_EN
    begin
      int cyc;
      mem[0] = '{opc: ADD, op_a: 1, op_b: 1};
      mem[1] = '{opc: DIV, op_a: 9, op_b: 0};
      mem[2] = '{opc: SUB, op_a: 4, op_b: 1};
      mem[3] = '{opc: PASSA, op_a: 6, op_b: 0};
      num_instr = CW'(4);
      start = 1'b1;
      step();
      start = 1'b0;
      check("stats_clear", {32'd0, exec_count, err_count}, 64'd0);
      cyc = 0;
      while (!done && cyc < 100) begin
        step();
        cyc++;
      end
      check("stats_done", 64'(done), 64'd1);
      check("stats_exec", 64'(exec_count), 64'd4);
      check("stats_err", 64'(err_count), 64'd1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_exec_reader.md
Name: instr_exec_reader

Overview:
Read-side consumer of the instruction register. On start, it walks read_pointer from 0 to num_instr-1 and captures each instruction_word. It executes each opcode on the signed operands and presents each result on a valid/ready output port. It sits beside instr_register and closes the loop that the write side (load_en/write_pointer) opens.

Parameters:
NUM_ENTRIES, 32, depth of instruction register; read_pointer wraps modulo this
RES_W, 64, result width; signed, holds full 32x32 product

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a run when idle, ignored otherwise
num_instr  input  $clog2(NUM_ENTRIES)+1  entries to execute; sampled on accepted start
read_pointer  output  $clog2(NUM_ENTRIES)  address driven to instr_register
instruction_word  input  instruction_t  combinational read data for read_pointer
result  output  RES_W  signed result of current instruction
result_opc  output  opcode_t  opcode that produced result
result_idx  output  $clog2(NUM_ENTRIES)  entry index of result
result_valid  output  1  result fields valid
result_ready  input  1  consumer accepts when valid&ready
div_err  output  1  current result came from DIV/MOD with op_b==0
busy  output  1  run in progress
done  output  1  one-cycle pulse after last result accepted

Behaviour:
- Reset (async, reset_n=0): state IDLE; read_pointer=0, result=0, result_opc=ZERO, result_idx=0, result_valid=0, div_err=0, busy=0, done=0. Reset mid-run aborts the run with no done.
- FSM states: IDLE -> FETCH -> EXEC -> OUT -> (FETCH | FIN) -> IDLE.
- IDLE: on start with num_instr>0, latch count, read_pointer=0, busy=1, go to FETCH. On start with num_instr==0, pulse done next cycle, stay IDLE, busy stays 0.
- FETCH: read_pointer stable; sample instruction_word at the clock edge into an internal register; go to EXEC.
- EXEC: compute result from the captured word; load result/result_opc/result_idx/div_err; assert result_valid; go to OUT. The first result_valid appears 3 cycles after start.
- OUT: hold all result fields stable while result_valid&&!result_ready. On handshake: drop result_valid; if the final entry is done, go to FIN, else increment read_pointer (wrap at NUM_ENTRIES-1 -> 0) and go to FETCH. Minimum 3 cycles per instruction.
- FIN: done=1 for one cycle, busy=0, return to IDLE. read_pointer keeps its last value.
- start while busy: ignored. num_instr > NUM_ENTRIES: clamp to NUM_ENTRIES.
- Arithmetic (op_a, op_b signed 32-bit, sign-extended to RES_W):
  - ZERO -> 0
  - PASSA -> op_a
  - PASSB -> op_b
  - ADD -> a+b
  - SUB -> a-b
  - MULT -> a*b (full 64-bit)
  - DIV -> a/b, truncating toward zero
  - MOD -> a%b, sign of a
- DIV/MOD with b==0: result=0, div_err=1. Otherwise div_err=0.
- Undefined opcode encoding: result=0, div_err=0.

Optional Feature:
INSTR_EXEC_STATS_EN
- Defined: adds outputs exec_count (16-bit) and err_count (16-bit). Both clear on reset and on an accepted start.
  - exec_count increments on each result handshake; err_count increments on handshakes with div_err=1.
  - Both saturate at 16'hFFFF.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- instr_register_pkg carries opcode_t, operand_t and instruction_t:
  - opcode_t: 4-bit enum ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7.
  - operand_t: signed 32-bit.
  - instruction_t: packed struct {opc, op_a, op_b}.
- Add to the package: the RES_W default as a localparam, plus a result_t typedef.
- One sub-module, instr_exec_alu: purely combinational; opcode_t plus two operands in, result and div_err out; instantiated once in EXEC.

Test Plan:
- Reset mid-OUT (result_valid=1, reset_n pulsed low) -> all outputs at reset values immediately, no done pulse; next start runs from entry 0.
- Entries {ADD,5,3},{SUB,5,8},{MULT,-4,7}, num_instr=3, ready tied high -> results 8, -3, -28 with idx 0,1,2; first result_valid 3 cycles after start; done pulse after the third handshake.
- {MULT,32'h7FFFFFFF,32'h7FFFFFFF} -> result 64'h3FFFFFFF00000001, no truncation.
- {DIV,-7,2} -> -3; {MOD,-7,2} -> -1; {DIV,9,0} -> result 0, div_err=1.
- result_ready held low 5 cycles with result_valid=1 -> result, result_opc and result_idx stable throughout, read_pointer unchanged; start pulsed during the stall is ignored.
- num_instr=0 -> done a single cycle, busy never asserted; with INSTR_EXEC_STATS_EN, a run containing 1 div-by-zero among 4 entries -> exec_count=4, err_count=1.
